// File: rtl/dp_ram_fwd_pipe_if.sv
// dp_ram_fwd_pipe_if: port bundle of the single-clock 1R1W RAM with forwarding and init sweep.
interface dp_ram_fwd_pipe_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
);
    logic                    INIT_REQ;
    logic                    INIT_DONE;
    logic                    CEA;
    logic [ADDR_WIDTH-1:0]   AA;
    logic [DATA_WIDTH-1:0]   QA;
    logic                    QA_VLD;
    logic                    CEB;
    logic [ADDR_WIDTH-1:0]   AB;
    logic [DATA_WIDTH-1:0]   DB;
    logic [DATA_WIDTH/8-1:0] BEB;
    logic                    PERR;
    modport master (
        output INIT_REQ, CEA, AA, CEB, AB, DB, BEB,
        input  INIT_DONE, QA, QA_VLD, PERR
    );
    modport slave (
        input  INIT_REQ, CEA, AA, CEB, AB, DB, BEB,
        output INIT_DONE, QA, QA_VLD, PERR
    );
endinterface

// File: rtl/dp_ram_fwd_pipe.sv
// dp_ram_fwd_pipe: 1R1W RAM, byte enables, read-during-write forwarding, RD_LAT 1/2, init sweep.
// Define DP_RAM_FWD_PARITY_EN to add per-byte even parity storage and the PERR strobe.
module dp_ram_fwd_pipe #(
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic           CLK,
    input logic           rst_n,
    dp_ram_fwd_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("dp_ram_fwd_pipe: RD_LAT must be 1 or 2");
    end

    typedef enum logic {INIT, READY} state_t;
    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    logic                  ready, rd, hit, rd_err, s_vld, s_err;
    logic [NB-1:0]         fwd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word, s_dat;

    always_ff @(posedge CLK or negedge rst_n)
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        if (state == INIT) begin
            cnt_nx   = bus.INIT_REQ ? '0 : cnt + 1'b1;
            state_nx = (!bus.INIT_REQ && &cnt) ? READY : INIT;
        end else if (bus.INIT_REQ)
            state_nx = INIT;
    end

    assign ready         = state == READY;
    assign bus.INIT_DONE = ready;
    assign rd            = ready & bus.CEA;
    assign hit           = bus.CEB && (bus.AB == bus.AA);
    assign fwd           = {NB{hit}} & bus.BEB;

    always_ff @(posedge CLK)
        if (!ready)
            mem[cnt] <= INIT_VALUE;
        else if (bus.CEB)
            for (int i = 0; i < NB; i++)
                if (bus.BEB[i]) mem[bus.AB][8*i +: 8] <= bus.DB[8*i +: 8];

`ifdef DP_RAM_FWD_PARITY_EN
    // Stored even-parity bit per byte; left unreset and reachable hierarchically for fault injection.
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] par_of(input logic [DATA_WIDTH-1:0] w);
        for (int i = 0; i < NB; i++) par_of[i] = ^w[8*i +: 8];
    endfunction

    always_ff @(posedge CLK)
        if (!ready)
            par_mem[cnt] <= par_of(INIT_VALUE);
        else if (bus.CEB)
            for (int i = 0; i < NB; i++)
                if (bus.BEB[i]) par_mem[bus.AB][i] <= ^bus.DB[8*i +: 8];
`endif

    always_comb begin
        rd_word = mem[bus.AA];
        rd_err  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (fwd[i]) rd_word[8*i +: 8] = bus.DB[8*i +: 8];
`ifdef DP_RAM_FWD_PARITY_EN
            rd_err = rd_err | (!fwd[i] && ((^mem[bus.AA][8*i +: 8]) != par_mem[bus.AA][i]));
`endif
        end
    end

    // Read data is captured at issue, so later writes never leak into an in-flight read.
    if (RD_LAT == 2) begin : g_lat2
        logic                  p_vld, p_err;
        logic [DATA_WIDTH-1:0] p_dat;
        always_ff @(posedge CLK or negedge rst_n)
            if (!rst_n) begin
                p_vld <= 1'b0;
                p_err <= 1'b0;
                p_dat <= '0;
            end else begin
                p_vld <= rd;
                p_err <= rd_err;
                p_dat <= rd_word;
            end
        assign s_vld = p_vld;
        assign s_err = p_err;
        assign s_dat = p_dat;
    end else begin : g_lat1
        assign s_vld = rd;
        assign s_err = rd_err;
        assign s_dat = rd_word;
    end

    always_ff @(posedge CLK or negedge rst_n)
        if (!rst_n) begin
            bus.QA     <= '0;
            bus.QA_VLD <= 1'b0;
            bus.PERR   <= 1'b0;
        end else begin
            bus.QA_VLD <= s_vld;
            bus.PERR   <= s_vld & s_err;
            if (s_vld) bus.QA <= s_dat;
        end
endmodule

// File: tb/tb_dp_ram_fwd_pipe.sv
// tb_dp_ram_fwd_pipe: directed bench driving RD_LAT=1 and RD_LAT=2 instances with identical stimulus.
module tb_dp_ram_fwd_pipe;
    localparam int          AW = 6;
    localparam int          DW = 64;
    localparam logic [63:0] IV = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] W5 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] F9 = 64'hA5A5_A5A5_FFFF_FFFF;
`ifdef DP_RAM_FWD_PARITY_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_seen;
    logic vld_seen;

    always #5 CLK = ~CLK;

    dp_ram_fwd_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
    dp_ram_fwd_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();

    assign b2.INIT_REQ = b1.INIT_REQ;
    assign b2.CEA      = b1.CEA;
    assign b2.AA       = b1.AA;
    assign b2.CEB      = b1.CEB;
    assign b2.AB       = b1.AB;
    assign b2.DB       = b1.DB;
    assign b2.BEB      = b1.BEB;

    dp_ram_fwd_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .INIT_VALUE(IV))
        dut1 (.CLK(CLK), .rst_n(rst_n), .bus(b1.slave));
    dp_ram_fwd_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2), .INIT_VALUE(IV))
        dut2 (.CLK(CLK), .rst_n(rst_n), .bus(b2.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        b1.INIT_REQ = 1'b0;
        b1.CEA      = 1'b0;
        b1.CEB      = 1'b0;
        b1.BEB      = '0;
    endtask

    task automatic drive(input logic cea, input logic [AW-1:0] aa, input logic ceb,
                         input logic [AW-1:0] ab, input logic [63:0] db, input logic [7:0] be);
        b1.CEA = cea;
        b1.AA  = aa;
        b1.CEB = ceb;
        b1.AB  = ab;
        b1.DB  = db;
        b1.BEB = be;
    endtask

    initial begin
        idle();
        b1.AA = '0;
        b1.AB = '0;
        b1.DB = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("rst_done", b1.INIT_DONE, 0);
        check("rst_qa", b1.QA, 0);
        check("rst_vld", b1.QA_VLD | b2.QA_VLD, 0);
        check("rst_perr", b1.PERR | b2.PERR, 0);

        // Release just after an edge; accesses during the sweep must be ignored
        @(posedge CLK);
        #1 rst_n = 1'b1;
        drive(1, 6'd0, 1, 6'd0, 64'h0, 8'hFF);
        vld_seen = 1'b0;
        repeat (63) begin
            tick();
            vld_seen |= b1.QA_VLD | b2.QA_VLD;
        end
        check("init_done_63", b1.INIT_DONE, 0);
        check("init_ignored", vld_seen, 0);
        tick();
        check("init_done_64", b1.INIT_DONE & b2.INIT_DONE, 1);
        idle();

        // Back-to-back reads of 63 and 0
        drive(1, 6'd63, 0, 6'd0, 64'h0, 8'h00);
        tick();
        b1.AA = 6'd0;
        check("rd63_l1_vld", b1.QA_VLD, 1);
        check("rd63_l1_qa", b1.QA, IV);
        check("rd63_l2_early", b2.QA_VLD, 0);
        tick();
        idle();
        check("rd0_l1_vld", b1.QA_VLD, 1);
        check("rd0_l1_qa", b1.QA, IV);
        check("rd63_l2_vld", b2.QA_VLD, 1);
        check("rd63_l2_qa", b2.QA, IV);
        tick();
        check("rd_l1_drop", b1.QA_VLD, 0);
        check("rd0_l2_vld", b2.QA_VLD, 1);
        tick();
        check("l2_hold_vld", b2.QA_VLD, 0);
        check("l2_hold_qa", b2.QA, IV);

        // Full write, then read with a BEB=0 write to the same address
        drive(0, 6'd0, 1, 6'd5, W5, 8'hFF);
        tick();
        drive(1, 6'd5, 1, 6'd5, 64'h0, 8'h00);
        tick();
        idle();
        check("w5_l1_qa", b1.QA, W5);
        check("w5_l1_perr", b1.PERR, 0);
        check("w5_l2_early", b2.QA_VLD, 0);
        tick();
        check("w5_l2_vld", b2.QA_VLD, 1);
        check("w5_l2_qa", b2.QA, W5);

        // Same-cycle partial write forwarding
        drive(1, 6'd9, 1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        tick();
        idle();
        check("fwd9_l1", b1.QA, F9);
        tick();
        check("fwd9_l2", b2.QA, F9);
        drive(1, 6'd9, 0, 6'd0, 64'h0, 8'h00);
        tick();
        idle();
        check("re9_l1", b1.QA, F9);
        tick();
        check("re9_l2", b2.QA, F9);

        // Write after read must not affect the in-flight read
        drive(0, 6'd0, 1, 6'd3, 64'h1, 8'hFF);
        tick();
        drive(1, 6'd3, 0, 6'd0, 64'h0, 8'h00);
        tick();
        drive(0, 6'd0, 1, 6'd3, 64'h2, 8'hFF);
        check("war_l1_old", b1.QA, 64'h1);
        tick();
        drive(1, 6'd3, 0, 6'd0, 64'h0, 8'h00);
        check("war_l2_old", b2.QA, 64'h1);
        check("war_l2_vld", b2.QA_VLD, 1);
        tick();
        idle();
        check("war_l1_new", b1.QA, 64'h2);
        tick();
        check("war_l2_new", b2.QA, 64'h2);

        // Re-init with a read in flight
        drive(1, 6'd5, 0, 6'd0, 64'h0, 8'h00);
        b1.INIT_REQ = 1'b1;
        tick();
        b1.INIT_REQ = 1'b0;
        drive(1, 6'd5, 1, 6'd5, 64'h0, 8'hFF);
        check("reinit_l1_qa", b1.QA, W5);
        check("reinit_done0", b1.INIT_DONE | b2.INIT_DONE, 0);
        tick();
        check("reinit_l2_vld", b2.QA_VLD, 1);
        check("reinit_l2_qa", b2.QA, W5);
        vld_seen  = 1'b0;
        done_seen = 0;
        repeat (62) begin
            tick();
            vld_seen |= b1.QA_VLD | b2.QA_VLD;
            done_seen += int'(b1.INIT_DONE);
        end
        check("reinit_ignored", vld_seen, 0);
        check("reinit_done_early", done_seen, 0);
        tick();
        check("reinit_done", b1.INIT_DONE & b2.INIT_DONE, 1);
        drive(1, 6'd5, 0, 6'd0, 64'h0, 8'h00);
        tick();
        idle();
        check("reinit_l1_a5", b1.QA, IV);
        tick();
        check("reinit_l2_a5", b2.QA, IV);

        // Parity fault on addr 7 byte 0 (PERR stays 0 without the parity build)
`ifdef DP_RAM_FWD_PARITY_EN
        dut1.par_mem[7][0] = ~dut1.par_mem[7][0];
        dut2.par_mem[7][0] = ~dut2.par_mem[7][0];
`endif
        drive(1, 6'd7, 0, 6'd0, 64'h0, 8'h00);
        tick();
        idle();
        check("par_l1_vld", b1.QA_VLD, 1);
        check("par_l1_perr", b1.PERR, EXP_PERR);
        tick();
        check("par_l2_perr", b2.PERR, EXP_PERR);
        tick();
        check("par_l2_drop", b2.PERR, 0);

        // Asynchronous reset mid-sweep at counter 30
        b1.INIT_REQ = 1'b1;
        tick();
        b1.INIT_REQ = 1'b0;
        repeat (30) tick();
        check("mid_qa_before", b1.QA, IV);
        rst_n = 1'b0;
        #1;
        check("mid_rst_qa", b1.QA | b2.QA, 0);
        check("mid_rst_vld", b1.QA_VLD | b2.QA_VLD, 0);
        check("mid_rst_done", b1.INIT_DONE, 0);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (63) tick();
        check("mid_done_63", b1.INIT_DONE, 0);
        tick();
        check("mid_done_64", b1.INIT_DONE & b2.INIT_DONE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_ram_fwd_pipe.md
Name: dp_ram_fwd_pipe

Overview:
- Single-clock 1R1W RAM wrapper. Successor to the two-clock dual-port RAM wrapper.
- Adds parametrised read latency, byte-granular write enables and full read-during-write forwarding.
- Adds a hardware initialisation sweep with re-init request.
- Sits under cache tag/data arrays and queue storage; the storage array is internal and fully behavioural.

Parameters:
- ADDR_WIDTH, 6: address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 64: word width; must be a multiple of 8.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2. Any other value is a $error at elaboration.
- INIT_VALUE, 0: DATA_WIDTH-bit word written to every address by the init sweep.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- INIT_REQ  in  1  pulse; restarts the init sweep.
- INIT_DONE  out  1  1 = array initialised, ports accepted.
- CEA  in  1  read enable.
- AA  in  ADDR_WIDTH  read address.
- QA  out  DATA_WIDTH  read data.
- QA_VLD  out  1  1-cycle strobe, QA updated this cycle.
- CEB  in  1  write enable.
- AB  in  ADDR_WIDTH  write address.
- DB  in  DATA_WIDTH  write data.
- BEB  in  DATA_WIDTH/8  byte write enable; 1 = write byte.
- PERR  out  1  parity error strobe (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): FSM=INIT, init counter=0, INIT_DONE=0, QA=0, QA_VLD=0, PERR=0, latency pipeline cleared. Array contents are not reset.
- FSM INIT:
  - One write per cycle of INIT_VALUE to address = counter; counter increments.
  - After the write to DEPTH-1, next state is READY. INIT_DONE=1 from the first READY cycle. A sweep takes exactly DEPTH cycles.
  - CEA/CEB are ignored (no array access, no QA_VLD) while INIT_DONE=0.
- FSM READY:
  - INIT_REQ=1 moves to INIT next cycle. Counter=0, INIT_DONE=0 that same next cycle.
  - Reads still in the pipeline complete normally.
  - INIT_REQ during INIT restarts the counter at 0.
- Write: CEB=1 in READY updates bytes i with BEB[i]=1 at the clock edge; other bytes are unchanged.
- Read issued at cycle t (CEA=1, READY):
  - QA_VLD=1 and QA valid at cycle t+RD_LAT.
  - Returned value = array contents after all writes up to and including cycle t.
  - Same-cycle write to AA==AB is forwarded byte-wise: QA byte i = DB byte i if BEB[i], else old word byte i.
  - RD_LAT=2: a write at t+1 to the same address is NOT reflected in that read.
- Back-to-back reads: one per cycle, fully pipelined, no bubbles.
- QA holds its last value until the next QA_VLD. QA_VLD is never asserted without a preceding accepted read.
- CEB with BEB=0: no array change, no forwarding effect.

Optional Feature:
- Macro: DP_RAM_FWD_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, written with the byte; the init sweep writes parity of INIT_VALUE.
  - On QA_VLD, PERR=1 for that cycle if any returned byte's stored parity mismatches (forwarded bytes are always parity-correct).
  - Parity storage is backdoor-accessible for fault injection.
- Not defined: no parity storage, PERR tied 0.

Test Plan:
- Reset, DEPTH=64, INIT_VALUE=0xA5A5... -> INIT_DONE rises exactly 64 cycles after rst_n release; read addr 63 returns 0xA5A5...; QA_VLD 1 cycle after CEA (RD_LAT=1).
- Write addr 5 =0x1122334455667788 BEB=0xFF, then read 5 -> QA=0x1122334455667788; RD_LAT=2 -> QA_VLD exactly 2 cycles after CEA.
- Same cycle: CEA AA=9, CEB AB=9 DB=0xFFFF_FFFF_FFFF_FFFF BEB=0x0F, old=0 -> QA=0x0000_0000_FFFF_FFFF. Next read of 9 returns same.
- RD_LAT=2: read 3 (old=0x1) at t, write 3=0x2 at t+1 -> QA at t+2=0x1; read at t+2 returns 0x2 at t+4.
- INIT_REQ pulse in READY with reads in flight -> pending QA_VLD delivered; CEA/CEB ignored for 64 cycles; previously written addr 5 reads INIT_VALUE afterwards.
- rst_n low mid-sweep (counter=30) -> INIT_DONE=0, QA=0, QA_VLD=0 immediately; full 64-cycle sweep restarts. With DP_RAM_FWD_PARITY_EN, flip stored parity bit of addr 7 byte 0, read 7 -> PERR=1 with QA_VLD.
